// File: rtl/cs_lookup_pipe.sv
// Purpose: prefix-window select plus masked priority CAM over a writable control store.
// Latency: 2 cycles from request acceptance to out_valid when out_ready is held high.
// Backpressure: output registers hold while out_valid && !out_ready; in_ready drops once S1 cannot drain.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake; in_bytes holds the fetched bytes (byte 0 = [7:0])
//   in_pref_sel              one-hot prefix length; the lowest set bit wins, all-zero means window 0
//   out_valid/out_ready      result handshake; out_entry/out_hit/out_idx/out_key/out_sel_err form the result
//   prog_we/prog_idx/...     single-entry store write; prog_clr invalidates every entry
//   miss_cnt                 saturating count of miss results loaded into the output registers
module cs_lookup_pipe #(
  parameter int NUM_WIN     = 4,
  parameter int KEY_BYTES   = 3,
  parameter int NUM_ENTRIES = 140,
  parameter int ENTRY_W     = 230,
  parameter int IDX_W       = 8,   // 2**IDX_W must cover NUM_ENTRIES
  parameter int CNT_W       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [(NUM_WIN-1+KEY_BYTES)*8-1:0]    in_bytes,
  input  logic [NUM_WIN-1:0]                    in_pref_sel,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ENTRY_W-1:0]                    out_entry,
  output logic                                  out_hit,
  output logic [IDX_W-1:0]                      out_idx,
  output logic [KEY_BYTES*8-1:0]                out_key,
  output logic                                  out_sel_err,
  input  logic                                  prog_we,
  input  logic [IDX_W-1:0]                      prog_idx,
  input  logic [KEY_BYTES*8-1:0]                prog_key,
  input  logic [KEY_BYTES*8-1:0]                prog_mask,
  input  logic [ENTRY_W-1:0]                    prog_data,
  input  logic                                  prog_clr,
  output logic [CNT_W-1:0]                      miss_cnt
);

  localparam int KEY_W = KEY_BYTES * 8;
  localparam logic [IDX_W:0] NUM_ENT_L = (IDX_W+1)'(NUM_ENTRIES);

  // Request captured in the first pipeline stage.
  typedef struct packed {
    logic [KEY_W-1:0] win;
    logic             sel_err;
  } s1_t;

  // ---------------------------------------------------------------------------
  // Window select
  // ---------------------------------------------------------------------------
  logic [KEY_W-1:0] sel_win;
  logic             sel_found;
  logic             sel_err;

  // Scan from window 0 upward so the lowest set select bit takes the window;
  // an all-zero select falls through to the window-0 default.
  always_comb begin
    sel_win   = in_bytes[KEY_W-1:0];
    sel_found = 1'b0;
    for (int k = 0; k < NUM_WIN; k++) begin
      if (in_pref_sel[k] && !sel_found) begin
        sel_win   = in_bytes[k*8 +: KEY_W];
        sel_found = 1'b1;
      end
    end
  end

  assign sel_err = !$onehot(in_pref_sel);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid;
  s1_t  s1_q;
  logic adv2;
  logic accept;

  // S1 moves into the output registers whenever they are empty or being drained.
  assign adv2     = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || adv2);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_q.win     <= sel_win;
      s1_q.sel_err <= sel_err;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control store
  // ---------------------------------------------------------------------------
  logic [NUM_ENTRIES-1:0] st_vld;
  logic [KEY_W-1:0]       st_key  [NUM_ENTRIES];
  logic [KEY_W-1:0]       st_mask [NUM_ENTRIES];
  logic [ENTRY_W-1:0]     st_data [NUM_ENTRIES];
  logic                   prog_ok;

  // Indices past the store depth are representable in IDX_W bits and dropped here.
  assign prog_ok = prog_we && !prog_clr && ({1'b0, prog_idx} < NUM_ENT_L);

  // Only the valid bits are reset; a stale key/mask/data is never used while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_vld <= '0;
    end else if (prog_clr) begin
      st_vld <= '0;
    end else if (prog_ok) begin
      st_vld[prog_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_ok) begin
      st_key[prog_idx]  <= prog_key;
      st_mask[prog_idx] <= prog_mask;
      st_data[prog_idx] <= prog_data;
    end
  end

  // ---------------------------------------------------------------------------
  // CAM compare on S1 (reads the store before any same-edge write)
  // ---------------------------------------------------------------------------
  logic               cam_hit;
  logic [IDX_W-1:0]   cam_idx;
  logic [ENTRY_W-1:0] cam_data;

  always_comb begin
    cam_hit  = 1'b0;
    cam_idx  = '0;
    cam_data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!cam_hit && st_vld[i] && (((st_key[i] ^ s1_q.win) & st_mask[i]) == '0)) begin
        cam_hit  = 1'b1;
        cam_idx  = IDX_W'(i);
        cam_data = st_data[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers and miss counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_entry   <= '0;
      out_hit     <= 1'b0;
      out_idx     <= '0;
      out_key     <= '0;
      out_sel_err <= 1'b0;
    end else if (adv2) begin
      out_valid   <= 1'b1;
      out_entry   <= cam_data;
      out_hit     <= cam_hit;
      out_idx     <= cam_idx;
      out_key     <= s1_q.win;
      out_sel_err <= s1_q.sel_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Counts misses as they are loaded, not when downstream consumes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (adv2 && !cam_hit && (miss_cnt != {CNT_W{1'b1}})) begin
      miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cs_lookup_pipe.sv
// Purpose: directed bench for cs_lookup_pipe (vector table plus multi-cycle sequences).
// Latency: drives on posedge+1, samples on posedge+1/+2, away from the active edge.
// Backpressure: exercises output stall, release ordering, and reset with requests in flight.
module tb_cs_lookup_pipe;

  localparam int NUM_WIN = 4;
  localparam int KEY_BYTES = 3;
  localparam int NUM_ENTRIES = 140;
  localparam int ENTRY_W = 230;
  localparam int IDX_W = 8;
  localparam int CNT_W = 2;
  localparam int IN_W = (NUM_WIN-1+KEY_BYTES)*8;
  localparam int KEY_W = KEY_BYTES*8;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_bytes;
  logic [NUM_WIN-1:0] in_pref_sel;
  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_entry;
  logic               out_hit;
  logic [IDX_W-1:0]   out_idx;
  logic [KEY_W-1:0]   out_key;
  logic               out_sel_err;
  logic               prog_we;
  logic [IDX_W-1:0]   prog_idx;
  logic [KEY_W-1:0]   prog_key;
  logic [KEY_W-1:0]   prog_mask;
  logic [ENTRY_W-1:0] prog_data;
  logic               prog_clr;
  logic [CNT_W-1:0]   miss_cnt;

  int checks = 0;
  int errors = 0;

  cs_lookup_pipe #(
    .NUM_WIN(NUM_WIN), .KEY_BYTES(KEY_BYTES), .NUM_ENTRIES(NUM_ENTRIES),
    .ENTRY_W(ENTRY_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bytes(in_bytes), .in_pref_sel(in_pref_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry), .out_hit(out_hit),
    .out_idx(out_idx), .out_key(out_key), .out_sel_err(out_sel_err),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_key(prog_key), .prog_mask(prog_mask),
    .prog_data(prog_data), .prog_clr(prog_clr), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [IN_W-1:0]    bytes;
    logic [NUM_WIN-1:0] sel;
    logic               hit;
    logic [IDX_W-1:0]   idx;
    logic [KEY_W-1:0]   key;
    logic               err;
    logic [CNT_W-1:0]   cnt;
  } vec_t;

  vec_t vt [9];
  logic [KEY_W-1:0] bp_key [4];
  logic             bp_hit [4];
  logic [IDX_W-1:0] bp_idx [4];
  logic [KEY_W-1:0] res_key [4];
  logic             res_hit [4];
  logic [IDX_W-1:0] res_idx [4];

  // Distinct, non-zero control word per entry index.
  function automatic logic [ENTRY_W-1:0] dat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {{26{b}}, 22'(i*3+1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic prog(input logic [IDX_W-1:0] ix, input logic [KEY_W-1:0] k,
                      input logic [KEY_W-1:0] m, input logic [ENTRY_W-1:0] d);
    prog_we = 1'b1; prog_idx = ix; prog_key = k; prog_mask = m; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Single request into an empty pipe; leaves the result on the output for sampling.
  task automatic do_lookup(input string nm, input logic [IN_W-1:0] b, input logic [NUM_WIN-1:0] s);
    in_bytes = b; in_pref_sel = s; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0; in_bytes = '0; in_pref_sel = '0;
    chk({nm, "_lat1_valid"}, out_valid, 0);
    tick();
    chk({nm, "_lat2_valid"}, out_valid, 1);
  endtask

  task automatic expect_res(input string nm, input logic h, input logic [IDX_W-1:0] ix,
                            input logic [KEY_W-1:0] k, input logic e, input logic [CNT_W-1:0] c);
    chk({nm, "_hit"}, out_hit, h);
    chk({nm, "_idx"}, out_idx, h ? ix : '0);
    chk({nm, "_entry"}, out_entry, h ? dat(int'(ix)) : '0);
    chk({nm, "_key"}, out_key, k);
    chk({nm, "_sel_err"}, out_sel_err, e);
    chk({nm, "_miss_cnt"}, miss_cnt, c);
  endtask

  initial begin
    int nacc;
    int nres;
    int extra;
    logic acc;

    //          bytes               sel      hit   idx      key          err   cnt
    vt[0] = '{48'hAA0F0F83BBCC, 4'b0100, 1'b1, 8'd5,   24'h0F0F83, 1'b0, 2'd0}; // window 2
    vt[1] = '{48'h1234560C0089, 4'b0001, 1'b1, 8'd3,   24'h0C0089, 1'b0, 2'd0}; // masked idx3 beats idx7
    vt[2] = '{48'h222222000000, 4'b1000, 1'b1, 8'd139, 24'h222222, 1'b0, 2'd0}; // last entry, window 3
    vt[3] = '{48'h000044444400, 4'b0010, 1'b1, 8'd0,   24'h444444, 1'b0, 2'd0}; // entry 0, window 1
    vt[4] = '{48'h000000111111, 4'b0001, 1'b0, 8'd0,   24'h111111, 1'b0, 2'd1}; // out-of-range write ignored
    vt[5] = '{48'hFFFFFF0F0F83, 4'b0000, 1'b1, 8'd5,   24'h0F0F83, 1'b1, 2'd1}; // zero select -> window 0
    vt[6] = '{48'h00000F0F8300, 4'b0110, 1'b1, 8'd5,   24'h0F0F83, 1'b1, 2'd1}; // multi-hot -> window 1
    vt[7] = '{48'hEE0C00891111, 4'b1100, 1'b1, 8'd3,   24'h0C0089, 1'b1, 2'd1}; // multi-hot -> window 2
    vt[8] = '{48'h0000000F0F82, 4'b0001, 1'b0, 8'd0,   24'h0F0F82, 1'b0, 2'd2}; // near miss

    bp_key[0] = 24'h0C0089; bp_hit[0] = 1'b1; bp_idx[0] = 8'd7;
    bp_key[1] = 24'h090909; bp_hit[1] = 1'b1; bp_idx[1] = 8'd9;
    bp_key[2] = 24'h777777; bp_hit[2] = 1'b0; bp_idx[2] = 8'd0;
    bp_key[3] = 24'h0C0089; bp_hit[3] = 1'b1; bp_idx[3] = 8'd7;

    rst = 1'b1; in_valid = 1'b0; in_bytes = '0; in_pref_sel = '0; out_ready = 1'b1;
    prog_we = 1'b0; prog_idx = '0; prog_key = '0; prog_mask = '0; prog_data = '0; prog_clr = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_entry", out_entry, 0);
    chk("rst_out_key", out_key, 0);
    chk("rst_out_sel_err", out_sel_err, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    tick();

    prog(8'd5,   24'h0F0F83, 24'hFFFFFF, dat(5));
    prog(8'd3,   24'h000089, 24'h0000FF, dat(3));
    prog(8'd7,   24'h0C0089, 24'hFFFFFF, dat(7));
    prog(8'd139, 24'h222222, 24'hFFFFFF, dat(139));
    prog(8'd0,   24'h444444, 24'hFFFFFF, dat(0));
    prog(8'd200, 24'h111111, 24'hFFFFFF, dat(200));

    for (int i = 0; i < 9; i++) begin
      do_lookup($sformatf("vec%0d", i), vt[i].bytes, vt[i].sel);
      expect_res($sformatf("vec%0d", i), vt[i].hit, vt[i].idx, vt[i].key, vt[i].err, vt[i].cnt);
    end

    // Clear wins over a same-cycle write: idx3 must stay invalid, so idx7 takes priority.
    prog_clr = 1'b1; prog_we = 1'b1; prog_idx = 8'd3;
    prog_key = 24'h000089; prog_mask = 24'h0000FF; prog_data = dat(3);
    tick();
    prog_clr = 1'b0; prog_we = 1'b0;
    prog(8'd7, 24'h0C0089, 24'hFFFFFF, dat(7));
    do_lookup("clr_prio", 48'h0000000C0089, 4'b0001);
    expect_res("clr_prio", 1'b1, 8'd7, 24'h0C0089, 1'b0, 2'd2);

    // Write lands on the same edge that loads the compare result: result uses old contents.
    in_bytes = 48'h000000090909; in_pref_sel = 4'b0001; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    prog_we = 1'b1; prog_idx = 8'd9; prog_key = 24'h090909; prog_mask = 24'hFFFFFF; prog_data = dat(9);
    tick();
    prog_we = 1'b0;
    chk("samecyc_valid", out_valid, 1);
    expect_res("samecyc", 1'b0, 8'd0, 24'h090909, 1'b0, 2'd3);
    do_lookup("after_write", 48'h000000090909, 4'b0001);
    expect_res("after_write", 1'b1, 8'd9, 24'h090909, 1'b0, 2'd3);

    // Counter saturates at 3 for CNT_W=2.
    do_lookup("sat4", 48'h000000777777, 4'b0001);
    expect_res("sat4", 1'b0, 8'd0, 24'h777777, 1'b0, 2'd3);
    do_lookup("sat5", 48'h000000777777, 4'b0001);
    expect_res("sat5", 1'b0, 8'd0, 24'h777777, 1'b0, 2'd3);
    tick();

    // Backpressure: stalled output admits exactly two requests, then holds the first result.
    out_ready = 1'b0; nacc = 0; nres = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (nacc < 4);
      in_bytes = {24'h0, bp_key[nacc < 4 ? nacc : 3]}; in_pref_sel = 4'b0001;
      #1;
      if (cyc >= 2) chk($sformatf("bp_hold_key_c%0d", cyc), out_key, 24'h0C0089);
      acc = in_valid && in_ready;
      tick();
      if (acc) nacc++;
    end
    chk("bp_accepts", nacc, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold_idx", out_idx, 8'd7);

    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && nres < 4; cyc++) begin
      in_valid = (nacc < 4);
      in_bytes = {24'h0, bp_key[nacc < 4 ? nacc : 3]}; in_pref_sel = 4'b0001;
      #1;
      if (out_valid) begin
        res_key[nres] = out_key; res_hit[nres] = out_hit; res_idx[nres] = out_idx;
        nres++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    chk("bp_total_accepts", nacc, 4);
    chk("bp_total_results", nres, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < nres) begin
        chk($sformatf("bp_res%0d_key", i), res_key[i], bp_key[i]);
        chk($sformatf("bp_res%0d_hit", i), res_hit[i], bp_hit[i]);
        chk($sformatf("bp_res%0d_idx", i), res_idx[i], bp_idx[i]);
      end
    end
    extra = 0;
    repeat (3) begin
      if (out_valid) extra++;
      tick();
    end
    chk("bp_no_dup", extra, 0);

    // Reset with one result stalled on the output and one request in S1.
    out_ready = 1'b0;
    in_bytes = 48'h0000000C0089; in_pref_sel = 4'b0001; in_valid = 1'b1;
    tick();
    in_bytes = 48'h000000090909;
    tick();
    in_valid = 1'b0;
    chk("rst2_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst2_in_ready_comb", in_ready, 0);
    tick();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_miss_cnt", miss_cnt, 0);
    chk("rst2_in_ready", in_ready, 0);
    rst = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (4) begin
      if (out_valid) extra++;
      tick();
    end
    chk("rst2_no_output", extra, 0);
    do_lookup("rst2_look7", 48'h0000000C0089, 4'b0001);
    expect_res("rst2_look7", 1'b0, 8'd0, 24'h0C0089, 1'b0, 2'd1);
    do_lookup("rst2_look9", 48'h000000090909, 4'b0001);
    expect_res("rst2_look9", 1'b0, 8'd0, 24'h090909, 1'b0, 2'd2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
